// File: rtl/piso_tx_if.sv
// piso_tx_if -- parallel-in / serial-out bus bundle.
//
// Handshake: a word moves from master to slave on a rising edge where
// DIN_VALID and DIN_READY are both 1. DIN_VALID may be raised at any time
// and is ignored while DIN_READY is 0. The serial side has no back-pressure:
// SOUT is a frame bit in every cycle where SVALID is 1, and SLAST marks the
// final bit of the frame.
//
// Signals:
//   DIN       [WIDTH-1:0] parallel word offered by the master
//   DIN_VALID             DIN holds a word
//   DIN_READY             slave accepts DIN at this edge
//   SOUT                  serial data bit (0 when SVALID=0)
//   SVALID                SOUT carries a frame bit
//   SLAST                 SOUT is the last bit of the frame
//   BUSY                  a frame is in progress (same as SVALID)
interface piso_tx_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] DIN;
  logic             DIN_VALID;
  logic             DIN_READY;
  logic             SOUT;
  logic             SVALID;
  logic             SLAST;
  logic             BUSY;

  modport master (
    output DIN, DIN_VALID,
    input  DIN_READY, SOUT, SVALID, SLAST, BUSY
  );

  modport slave (
    input  DIN, DIN_VALID,
    output DIN_READY, SOUT, SVALID, SLAST, BUSY
  );
endinterface

// File: rtl/piso_tx.sv
// piso_tx -- serialises a WIDTH-bit parallel word into a frame of single
// bits, one per clock, with back-to-back frames when a new word is offered
// during the final bit of the current one.
//
// Parameters:
//   WIDTH      parallel word width (>= 1)
//   MSB_FIRST  1: bit WIDTH-1 sent first; 0: bit 0 sent first
//
// Optional feature (macro PISO_TX_PARITY_EN): appends an even-parity bit
// (XOR of the captured data bits) after the data bits; the frame becomes
// WIDTH+1 bits and SLAST rides on the parity bit.
//
// Ports:
//   CLK        clock, all state changes on its rising edge
//   RST        synchronous active-high reset
//   bus        piso_tx_if slave modport (DIN/DIN_VALID/DIN_READY,
//              SOUT/SVALID/SLAST/BUSY)
//   dbg_state  current FSM state (0 = IDLE, 1 = SHIFT)
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic         CLK,
  input  logic         RST,
  piso_tx_if.slave     bus,
  output logic         dbg_state
);

`ifdef PISO_TX_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CNT_W = (FRAME_LEN + 1 > 2) ? $clog2(FRAME_LEN + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;      // index of the bit currently on SOUT
  logic [WIDTH-1:0] sreg, sreg_next;    // next data bit always sits at the output end
  logic             svalid;
  logic             last;
  logic             ready;
  logic             accept;
  logic             sout_bit;

`ifdef PISO_TX_PARITY_EN
  localparam logic [CNT_W-1:0] PAR_IDX = CNT_W'(WIDTH);
  logic parity_q, parity_next;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
`ifdef PISO_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      sreg  <= sreg_next;
`ifdef PISO_TX_PARITY_EN
      parity_q <= parity_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    sreg_next  = sreg;
`ifdef PISO_TX_PARITY_EN
    parity_next = parity_q;
`endif

    svalid = (state == SHIFT);
    last   = svalid && (cnt == LAST_IDX);
    // Ready in IDLE and on the final bit, so a waiting word follows with no gap.
    ready  = !RST && (!svalid || last);
    accept = bus.DIN_VALID && ready;

    sout_bit = (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];
`ifdef PISO_TX_PARITY_EN
    if (cnt == PAR_IDX) begin
      sout_bit = parity_q;
    end
`endif

    case (state)
      IDLE: begin
        cnt_next = '0;
      end
      SHIFT: begin
        if (last) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next  = cnt + CNT_W'(1);
          sreg_next = (MSB_FIRST != 0) ? (sreg << 1) : (sreg >> 1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    // A capture overrides both the return to IDLE and the shift.
    if (accept) begin
      state_next = SHIFT;
      cnt_next   = '0;
      sreg_next  = bus.DIN;
`ifdef PISO_TX_PARITY_EN
      parity_next = ^bus.DIN;
`endif
    end
  end

  assign bus.DIN_READY = ready;
  assign bus.SVALID    = svalid;
  assign bus.BUSY      = svalid;
  assign bus.SLAST     = last;
  assign bus.SOUT      = svalid & sout_bit;
  assign dbg_state     = (state == SHIFT);

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the parallel word width in bits (WIDTH >= 1).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 sent first, 0 = bit 0 sent first.
REQ-003 The block SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port DIN  input  WIDTH  parallel word to transmit.
REQ-006 The block SHALL have port DIN_VALID  input  1  DIN holds a word offered for transmission.
REQ-007 The block SHALL have port DIN_READY  output  1  block accepts DIN at this rising edge if DIN_VALID=1.
REQ-008 The block SHALL have port SOUT  output  1  serial data bit.
REQ-009 The block SHALL have port SVALID  output  1  SOUT carries a frame bit this cycle.
REQ-010 The block SHALL have port SLAST  output  1  current SOUT bit is the last bit of the frame.
REQ-011 The block SHALL have port BUSY  output  1  a frame is in progress (equals SVALID).

Function
REQ-012 The block SHALL have two states: IDLE and SHIFT, plus a bit counter of ceil(log2(FRAME_LEN+1)) bits, where FRAME_LEN = WIDTH (or WIDTH+1 per REQ-027).
REQ-013 The handshake SHALL complete when DIN_VALID=1 and DIN_READY=1 at a rising edge; DIN is captured into an internal shift register at that edge.
REQ-014 In IDLE: DIN_READY=1, SVALID=0, SLAST=0, SOUT=0.
REQ-015 On handshake in IDLE, the block SHALL enter SHIFT; the first frame bit SHALL appear on SOUT with SVALID=1 in the cycle immediately after the capturing edge (latency 1).
REQ-016 In SHIFT, exactly one bit SHALL be output per cycle for FRAME_LEN consecutive cycles, with order per MSB_FIRST.
REQ-017 SLAST SHALL be 1 only during the final bit cycle of a frame.
REQ-018 In SHIFT, DIN_READY SHALL be 0 except during the final bit cycle, where it SHALL be 1.
REQ-019 A handshake during the final bit cycle SHALL start the next frame in the following cycle with no idle gap (SVALID stays 1).
REQ-020 With no handshake during the final bit cycle, the block SHALL return to IDLE, with SVALID=0 in the next cycle.
REQ-021 DIN_VALID while DIN_READY=0 SHALL be ignored; changes on DIN after capture SHALL NOT affect the frame in progress.
REQ-022 With WIDTH=1 (no parity), every bit cycle is the final cycle: SLAST=1 and DIN_READY=1 whenever SVALID=1.
REQ-023 SOUT SHALL be 0 whenever SVALID=0.

Reset
REQ-024 While RST=1 at a rising edge, the block SHALL enter IDLE and clear the counter and shift register; after that edge SOUT=0, SVALID=0, SLAST=0, BUSY=0.
REQ-025 DIN_READY SHALL be 0 while RST=1, and 1 in the first cycle after RST is sampled low.
REQ-026 RST asserted mid-frame SHALL abort the frame with no further bits sent; DIN_VALID during RST=1 SHALL NOT be captured.

Configuration
REQ-027 With macro PISO_TX_PARITY_EN defined, FRAME_LEN = WIDTH+1: an even-parity bit (XOR of all captured data bits) SHALL be appended after the data bits and SHALL carry SLAST=1.
REQ-028 With PISO_TX_PARITY_EN undefined, FRAME_LEN = WIDTH, no parity bit is sent, and no parity logic SHALL be present.

Verification (WIDTH=4, MSB_FIRST=1, no parity unless stated)
REQ-029 Reset, then DIN=4'b1010 with DIN_VALID for one cycle -> SOUT 1,0,1,0 on the next 4 cycles with SVALID=1 and SLAST=1 on the 4th only; then IDLE with SVALID=0 and SOUT=0.
REQ-030 DIN=4'h3 then 4'hC, DIN_VALID held high -> 8 contiguous SVALID cycles with bits 0,0,1,1,1,1,0,0; DIN_READY=1 only in IDLE and in bit cycles 4 and 8.
REQ-031 During a 4'h5 frame, DIN=4'hF held valid from bit cycle 1 -> frame remains 0,1,0,1; 4'hF is captured only at bit cycle 4 and sent next as 1,1,1,1.
REQ-032 RST=1 at bit cycle 2 of a 4'hA frame -> next cycle SVALID=0, SOUT=0, DIN_READY=0; after RST is released, DIN_READY=1 and no remaining bits are emitted.
REQ-033 PISO_TX_PARITY_EN defined, DIN=4'b1011 -> SOUT 1,0,1,1,1 with SLAST on the 5th bit; DIN=4'b0011 -> parity bit 0.
REQ-034 MSB_FIRST=0, DIN=4'b0001 -> SOUT 1,0,0,0; with WIDTH=1, DIN=1 held valid -> SOUT=1, SLAST=1 and SVALID=1 every cycle.
